// File: rtl/glitch_trigger_qualifier.sv
// Turns a raw asynchronous target pin into a clean trigger level. The pin is synchronised,
// min-width filtered and edge-counted, and the trigger is raised once N qualified edges have been seen.
module glitch_trigger_qualifier #(
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 16,
    parameter int FILT_W      = 8,
    parameter int TMO_W       = 32
) (
    input  logic              i_PLL_Clk,
    input  logic              i_Rst_L,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic [1:0]        i_edge_sel,
    input  logic [CNT_W-1:0]  i_edge_count,
    input  logic [FILT_W-1:0] i_min_width,
    input  logic [TMO_W-1:0]  i_timeout,
    input  logic              i_target_io,
    output logic              o_trigger,
    output logic              o_armed,
    output logic              o_fired,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_edge_cnt
);

    // state   | meaning
    // IDLE    | disarmed, edges ignored
    // WAIT    | armed, counting qualified edges, timeout running
    // DONE    | target reached, o_trigger held high
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [FILT_W-1:0]      fc;
    logic [1:0]             sel_q;
    logic [CNT_W-1:0]       tgt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [TMO_W-1:0]       tmo_next;
    logic [CNT_W-1:0]       cnt_next;
    logic                   rise;
    logic                   fall;
    logic                   edge_hit;
    logic                   fire;
    logic                   tmo_hit;

    always_ff @(posedge i_PLL_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_target_io};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A change at s must persist i_min_width+1 cycles; any return to r_filt restarts the count.
    always_ff @(posedge i_PLL_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            fc       <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (s == r_filt) begin
                fc <= '0;
            end else if (fc == i_min_width) begin
                r_filt <= s;
                fc     <= '0;
            end else begin
                fc <= fc + FILT_W'(1);
            end
        end
    end

    assign rise = r_filt & ~r_filt_d;
    assign fall = ~r_filt & r_filt_d;

    always_comb begin
        edge_hit = rise;
        case (sel_q)
            2'b01:   edge_hit = fall;
            2'b10:   edge_hit = rise | fall;
            default: edge_hit = rise;
        endcase
    end

    assign cnt_next = o_edge_cnt + CNT_W'(1);
    assign tmo_next = tmo_cnt + TMO_W'(1);
    assign fire     = edge_hit && (cnt_next == tgt_q);
    assign tmo_hit  = (tmo_q != '0) && (tmo_next == tmo_q);
    assign o_armed  = (state == ST_WAIT);

    always_ff @(posedge i_PLL_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= ST_IDLE;
            sel_q      <= 2'b00;
            tgt_q      <= '0;
            tmo_q      <= '0;
            tmo_cnt    <= '0;
            o_trigger  <= 1'b0;
            o_fired    <= 1'b0;
            o_timeout  <= 1'b0;
            o_edge_cnt <= '0;
        end else if (i_abort) begin
            state     <= ST_IDLE;
            o_trigger <= 1'b0;
        end else if (i_arm) begin
            state      <= ST_WAIT;
            sel_q      <= i_edge_sel;
            tgt_q      <= (i_edge_count == '0) ? CNT_W'(1) : i_edge_count;
            tmo_q      <= i_timeout;
            tmo_cnt    <= '0;
            o_trigger  <= 1'b0;
            o_fired    <= 1'b0;
            o_timeout  <= 1'b0;
            o_edge_cnt <= '0;
        end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_next;
            if (edge_hit) begin
                o_edge_cnt <= cnt_next;
            end
            // The final edge wins over a timeout landing on the same cycle.
            if (fire) begin
                o_trigger <= 1'b1;
                o_fired   <= 1'b1;
                state     <= ST_DONE;
            end else if (tmo_hit) begin
                o_timeout <= 1'b1;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_glitch_trigger_qualifier.sv
// Directed and randomised checks of glitch_trigger_qualifier against a pulse-level model
// (accepted pulses, selected edges, latency SYNC_STAGES+W+2 from the pin change).
module tb_glitch_trigger_qualifier;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        arm = 1'b0;
    logic        abort_p = 1'b0;
    logic [1:0]  edge_sel = 2'b00;
    logic [15:0] edge_count = 16'd1;
    logic [7:0]  min_width = 8'd0;
    logic [31:0] timeout = 32'd0;
    logic        io = 1'b0;
    logic        trig;
    logic        armed;
    logic        fired;
    logic        tmo;
    logic [15:0] ecnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trig_rise = -1;
    int armed_cycles = 0;
    logic trig_prev = 1'b0;

    glitch_trigger_qualifier dut (
        .i_PLL_Clk   (clk),
        .i_Rst_L     (rst_l),
        .i_arm       (arm),
        .i_abort     (abort_p),
        .i_edge_sel  (edge_sel),
        .i_edge_count(edge_count),
        .i_min_width (min_width),
        .i_timeout   (timeout),
        .i_target_io (io),
        .o_trigger   (trig),
        .o_armed     (armed),
        .o_fired     (fired),
        .o_timeout   (tmo),
        .o_edge_cnt  (ecnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trig && !trig_prev) trig_rise <= cyc;
        trig_prev <= trig;
        if (armed) armed_cycles <= armed_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse(input int width, input int gap);
        io = 1'b1;
        tick(width);
        io = 1'b0;
        tick(gap);
    endtask

    task automatic set_cfg(input int sel, input int cnt, input int w, input int t);
        edge_sel   = 2'(sel);
        edge_count = 16'(cnt);
        min_width  = 8'(w);
        timeout    = 32'(t);
    endtask

    initial begin
        int t0, a0, w, c, sel, tgt, n, width, nsel, exp_fire, exp_cnt, ts, te;

        tick(3);
        check("reset_trigger", trig, 0);
        check("reset_armed", armed, 0);
        check("reset_edge_cnt", ecnt, 0);
        rst_l = 1'b1;
        tick(2);

        // three rising edges, no filter
        set_cfg(0, 3, 0, 0);
        arm_pulse();
        tick(2);
        pulse(10, 10);
        pulse(10, 10);
        check("t2_cnt_after_two", ecnt, 2);
        check("t2_no_trigger_yet", trig, 0);
        io = 1'b1;
        t0 = cyc;
        tick(10);
        io = 1'b0;
        tick(5);
        check("t2_latency", trig_rise - t0, 5);
        check("t2_edge_cnt", ecnt, 3);
        check("t2_fired", fired, 1);
        check("t2_trigger", trig, 1);
        check("t2_armed_done", armed, 0);

        // asynchronous reset while the trigger is high
        #2;
        rst_l = 1'b0;
        #1;
        check("t1_trigger", trig, 0);
        check("t1_armed", armed, 0);
        check("t1_fired", fired, 0);
        check("t1_timeout", tmo, 0);
        check("t1_edge_cnt", ecnt, 0);
        tick(2);
        rst_l = 1'b1;
        tick(2);

        // min-width filter
        set_cfg(0, 1, 4, 0);
        arm_pulse();
        tick(2);
        pulse(3, 15);
        check("t3_short_rejected", ecnt, 0);
        check("t3_short_no_trig", trig, 0);
        io = 1'b1;
        t0 = cyc;
        tick(6);
        io = 1'b0;
        tick(15);
        check("t3_latency", trig_rise - t0, 9);
        check("t3_edge_cnt", ecnt, 1);
        check("t3_fired", fired, 1);

        // timeout with no edges
        set_cfg(0, 1, 0, 100);
        a0 = armed_cycles;
        arm_pulse();
        tick(120);
        check("t4_armed_cycles", armed_cycles - a0, 100);
        check("t4_timeout", tmo, 1);
        check("t4_trigger", trig, 0);
        check("t4_armed", armed, 0);
        check("t4_fired", fired, 0);

        // final edge lands on the timeout cycle: fire wins
        set_cfg(0, 1, 0, 9);
        arm_pulse();
        tick(4);
        pulse(10, 10);
        check("tmo_tie_fired", fired, 1);
        check("tmo_tie_timeout", tmo, 0);
        check("tmo_tie_trigger", trig, 1);

        // one cycle earlier timeout beats the edge
        set_cfg(0, 1, 0, 8);
        arm_pulse();
        tick(4);
        pulse(10, 10);
        check("tmo_early_fired", fired, 0);
        check("tmo_early_timeout", tmo, 1);
        check("tmo_early_cnt", ecnt, 0);

        // both edges, then abort in DONE
        set_cfg(2, 4, 0, 0);
        arm_pulse();
        tick(2);
        pulse(8, 8);
        io = 1'b1;
        tick(8);
        io = 1'b0;
        t0 = cyc;
        tick(10);
        check("t5_latency", trig_rise - t0, 5);
        check("t5_edge_cnt", ecnt, 4);
        check("t5_fired", fired, 1);
        abort_p = 1'b1;
        tick(1);
        abort_p = 1'b0;
        check("t5_abort_trigger", trig, 0);
        check("t5_abort_fired", fired, 1);
        check("t5_abort_cnt", ecnt, 4);

        // arm+abort together in IDLE, then re-arm from DONE
        arm = 1'b1;
        abort_p = 1'b1;
        tick(1);
        arm = 1'b0;
        abort_p = 1'b0;
        check("t6_arm_abort_idle", armed, 0);
        set_cfg(0, 1, 0, 0);
        arm_pulse();
        tick(2);
        pulse(4, 10);
        check("t6_done_trigger", trig, 1);
        arm_pulse();
        check("t6_rearm_trigger", trig, 0);
        check("t6_rearm_cnt", ecnt, 0);
        check("t6_rearm_armed", armed, 1);
        check("t6_rearm_fired", fired, 0);
        abort_p = 1'b1;
        tick(1);
        abort_p = 1'b0;

        // randomised pulse trains against the pulse-level model
        for (int it = 0; it < 25; it++) begin
            w   = int'($urandom_range(0, 5));
            c   = int'($urandom_range(0, 4));
            sel = int'($urandom_range(0, 3));
            tgt = (c == 0) ? 1 : c;
            set_cfg(sel, c, w, 0);
            io = 1'b0;
            tick(w + 8);
            arm_pulse();
            tick(2);
            n = int'($urandom_range(1, 6));
            nsel = 0;
            exp_fire = -1;
            for (int p = 0; p < n; p++) begin
                width = int'($urandom_range(1, 2 * w + 4));
                io = 1'b1;
                ts = cyc;
                tick(width);
                io = 1'b0;
                te = cyc;
                if (width >= w + 1) begin
                    if (sel != 1) begin
                        nsel++;
                        if (nsel == tgt) exp_fire = ts + w + 5;
                    end
                    if (sel == 1 || sel == 2) begin
                        nsel++;
                        if (nsel == tgt) exp_fire = te + w + 5;
                    end
                end
                tick(w + 8);
            end
            tick(4);
            exp_cnt = (nsel < tgt) ? nsel : tgt;
            check($sformatf("rnd%0d_edge_cnt", it), ecnt, exp_cnt);
            check($sformatf("rnd%0d_fired", it), fired, (nsel >= tgt) ? 1 : 0);
            check($sformatf("rnd%0d_trigger", it), trig, (nsel >= tgt) ? 1 : 0);
            if (exp_fire >= 0) check($sformatf("rnd%0d_fire_cycle", it), trig_rise, exp_fire);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
